// File: rtl/prog_sequencer_if.sv
// Host/decoder-facing handshake bundle for prog_sequencer.
// The slave modport is the sequencer; the master modport is the host/decoder side.
interface prog_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [1:0]       prog_sel;
  logic             halt;
  logic             br_taken;
  logic             pc_reset;
  logic [1:0]       pc_state;
  logic             br_ctrl;
  logic             fetch_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles;
  logic             timeout;

  modport slave (
    input  start, prog_sel, halt, br_taken,
    output pc_reset, pc_state, br_ctrl, fetch_en, busy, done, cycles, timeout
  );

  modport master (
    output start, prog_sel, halt, br_taken,
    input  pc_reset, pc_state, br_ctrl, fetch_en, busy, done, cycles, timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller for the program counter: IDLE -> LOAD -> RUN -> DONE, with run-cycle count.
// Optional watchdog enabled by defining WATCHDOG_EN (limit set by MAX_CYCLES).
module prog_sequencer #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input logic              CLK,
  input logic              reset,
  prog_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       pc_state_q, pc_state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic             pc_reset_q, pc_reset_d;
  logic             fetch_en_q, fetch_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef WATCHDOG_EN
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(MAX_CYCLES - 1);
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    pc_state_d = pc_state_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d    = StLoad;
          pc_state_d = bus.prog_sel;
          cycles_d   = '0;
          timeout_d  = 1'b0;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        // Saturate rather than wrap so a long program never reads back as short.
        if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
        if (bus.halt) begin
          state_d = StDone;
        end
`ifdef WATCHDOG_EN
        if (cycles_q == WdLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // Moore outputs registered from the next state so they line up with state_q.
    pc_reset_d = (state_d == StLoad);
    fetch_en_d = (state_d == StRun);
    busy_d     = (state_d == StLoad) || (state_d == StRun);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_state_q <= 2'b00;
      cycles_q   <= '0;
      timeout_q  <= 1'b0;
      pc_reset_q <= 1'b0;
      fetch_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_state_q <= pc_state_d;
      cycles_q   <= cycles_d;
      timeout_q  <= timeout_d;
      pc_reset_q <= pc_reset_d;
      fetch_en_q <= fetch_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.pc_reset = pc_reset_q;
  assign bus.pc_state = pc_state_q;
  assign bus.fetch_en = fetch_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cycles   = cycles_q;
  assign bus.br_ctrl  = bus.br_taken & (state_q == StRun);
`ifdef WATCHDOG_EN
  assign bus.timeout  = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_q;
  assign bus.timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer; a second instance with MAX_CYCLES=8
// covers the watchdog (expectations switch on WATCHDOG_EN).
module tb_prog_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prog_sequencer_if #(.CNT_W(16)) bus ();
  prog_sequencer_if #(.CNT_W(16)) bus8 ();

  prog_sequencer #(.CNT_W(16)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  prog_sequencer #(.CNT_W(16), .MAX_CYCLES(8)) dut8 (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.prog_sel = 0; bus.halt = 0; bus.br_taken = 0;
    bus8.start = 0; bus8.prog_sel = 0; bus8.halt = 0; bus8.br_taken = 0;
    rst_n = 0;
    #12;
    n_tests++; if (bus.pc_reset !== 1'b0) begin n_fail++; $display("FAIL reset_pc_reset got %b exp 0", bus.pc_reset); end
    n_tests++; if (bus.fetch_en !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_en got %b exp 0", bus.fetch_en); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_tests++; if (bus.cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cycles got %0d exp 0", bus.cycles); end
    n_tests++; if (bus.pc_state !== 2'd0) begin n_fail++; $display("FAIL reset_pc_state got %0d exp 0", bus.pc_state); end
    n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_start_load();
    bus.br_taken = 1; #1;
    n_tests++; if (bus.br_ctrl !== 1'b0) begin n_fail++; $display("FAIL idle_br_ctrl got %b exp 0", bus.br_ctrl); end
    bus.br_taken = 0;
    bus.start = 1; bus.prog_sel = 2'd1;
    tick();
    bus.start = 0; bus.prog_sel = 2'd0;
    n_tests++; if (bus.pc_reset !== 1'b1) begin n_fail++; $display("FAIL load_pc_reset got %b exp 1", bus.pc_reset); end
    n_tests++; if (bus.pc_state !== 2'd1) begin n_fail++; $display("FAIL load_pc_state got %0d exp 1", bus.pc_state); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b exp 1", bus.busy); end
    n_tests++; if (bus.fetch_en !== 1'b0) begin n_fail++; $display("FAIL load_fetch_en got %b exp 0", bus.fetch_en); end
    tick();
    n_tests++; if (bus.pc_reset !== 1'b0) begin n_fail++; $display("FAIL run_pc_reset got %b exp 0", bus.pc_reset); end
    n_tests++; if (bus.fetch_en !== 1'b1) begin n_fail++; $display("FAIL run_fetch_en got %b exp 1", bus.fetch_en); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL run_busy got %b exp 1", bus.busy); end
    n_tests++; if (bus.pc_state !== 2'd1) begin n_fail++; $display("FAIL run_pc_state got %0d exp 1", bus.pc_state); end
  endtask

  task automatic test_run_halt();
    for (int i = 0; i < 10; i++) tick();
    n_tests++; if (bus.cycles !== 16'd10) begin n_fail++; $display("FAIL run10_cycles got %0d exp 10", bus.cycles); end
    bus.halt = 1;
    tick();
    bus.halt = 0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL halt_done got %b exp 1", bus.done); end
    n_tests++; if (bus.fetch_en !== 1'b0) begin n_fail++; $display("FAIL halt_fetch_en got %b exp 0", bus.fetch_en); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.cycles !== 16'd11) begin n_fail++; $display("FAIL halt_cycles got %0d exp 11", bus.cycles); end
    // halt and br_taken are ignored while DONE
    bus.halt = 1; bus.br_taken = 1;
    #1;
    n_tests++; if (bus.br_ctrl !== 1'b0) begin n_fail++; $display("FAIL done_br_ctrl got %b exp 0", bus.br_ctrl); end
    tick(); tick();
    bus.halt = 0; bus.br_taken = 0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL done_hold got %b exp 1", bus.done); end
    n_tests++; if (bus.cycles !== 16'd11) begin n_fail++; $display("FAIL done_hold_cycles got %0d exp 11", bus.cycles); end
  endtask

  task automatic test_restart_branch();
    bus.start = 1; bus.prog_sel = 2'd2;
    tick();
    bus.start = 0; bus.prog_sel = 2'd0;
    n_tests++; if (bus.pc_state !== 2'd2) begin n_fail++; $display("FAIL restart_pc_state got %0d exp 2", bus.pc_state); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL restart_done got %b exp 0", bus.done); end
    n_tests++; if (bus.cycles !== 16'd0) begin n_fail++; $display("FAIL restart_cycles got %0d exp 0", bus.cycles); end
    n_tests++; if (bus.pc_reset !== 1'b1) begin n_fail++; $display("FAIL restart_pc_reset got %b exp 1", bus.pc_reset); end
    tick();
    bus.br_taken = 1; #1;
    n_tests++; if (bus.br_ctrl !== 1'b1) begin n_fail++; $display("FAIL run_br_ctrl got %b exp 1", bus.br_ctrl); end
    bus.br_taken = 0; #1;
    n_tests++; if (bus.br_ctrl !== 1'b0) begin n_fail++; $display("FAIL run_br_ctrl_low got %b exp 0", bus.br_ctrl); end
    bus.start = 1; bus.prog_sel = 2'd3;
    tick();
    n_tests++; if (bus.fetch_en !== 1'b1) begin n_fail++; $display("FAIL run_start_ignored got %b exp 1", bus.fetch_en); end
    n_tests++; if (bus.pc_reset !== 1'b0) begin n_fail++; $display("FAIL run_start_pc_reset got %b exp 0", bus.pc_reset); end
    n_tests++; if (bus.pc_state !== 2'd2) begin n_fail++; $display("FAIL run_start_pc_state got %0d exp 2", bus.pc_state); end
    bus.halt = 1;
    tick();
    bus.start = 0; bus.halt = 0; bus.prog_sel = 2'd0;
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL start_halt_done got %b exp 1", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_halt_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.cycles !== 16'd2) begin n_fail++; $display("FAIL start_halt_cycles got %0d exp 2", bus.cycles); end
  endtask

  task automatic test_midrun_reset();
    bus.start = 1; bus.prog_sel = 2'd3;
    tick();
    bus.start = 0;
    tick(); tick(); tick();
    #2;
    rst_n = 0;
    #1;
    n_tests++; if (bus.fetch_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fetch_en got %b exp 0", bus.fetch_en); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.pc_reset !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pc_reset got %b exp 0", bus.pc_reset); end
    n_tests++; if (bus.cycles !== 16'd0) begin n_fail++; $display("FAIL mid_reset_cycles got %0d exp 0", bus.cycles); end
    n_tests++; if (bus.pc_state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_pc_state got %0d exp 0", bus.pc_state); end
    @(negedge clk);
    rst_n = 1;
    tick(); tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL post_reset_done got %b exp 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_watchdog();
    bus8.start = 1; bus8.prog_sel = 2'd1;
    tick();
    bus8.start = 0;
    tick();
    n_tests++; if (bus8.fetch_en !== 1'b1) begin n_fail++; $display("FAIL wd_run_fetch_en got %b exp 1", bus8.fetch_en); end
    for (int i = 0; i < 8; i++) tick();
`ifdef WATCHDOG_EN
    n_tests++; if (bus8.done !== 1'b1) begin n_fail++; $display("FAIL wd_done got %b exp 1", bus8.done); end
    n_tests++; if (bus8.timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout got %b exp 1", bus8.timeout); end
    n_tests++; if (bus8.cycles !== 16'd8) begin n_fail++; $display("FAIL wd_cycles got %0d exp 8", bus8.cycles); end
    tick();
    n_tests++; if (bus8.timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b exp 1", bus8.timeout); end
    bus8.start = 1;
    tick();
    bus8.start = 0;
    n_tests++; if (bus8.timeout !== 1'b0) begin n_fail++; $display("FAIL wd_clear got %b exp 0", bus8.timeout); end
`else
    n_tests++; if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL nowd_done got %b exp 0", bus8.done); end
    n_tests++; if (bus8.fetch_en !== 1'b1) begin n_fail++; $display("FAIL nowd_fetch_en got %b exp 1", bus8.fetch_en); end
    n_tests++; if (bus8.timeout !== 1'b0) begin n_fail++; $display("FAIL nowd_timeout got %b exp 0", bus8.timeout); end
    n_tests++; if (bus8.cycles !== 16'd8) begin n_fail++; $display("FAIL nowd_cycles got %0d exp 8", bus8.cycles); end
    tick();
    n_tests++; if (bus8.cycles !== 16'd9) begin n_fail++; $display("FAIL nowd_cycles9 got %0d exp 9", bus8.cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_start_load();
    test_run_halt();
    test_restart_branch();
    test_midrun_reset();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
